tag_packer: RTL

//  Packs timestamp events from the tagger core into 6-byte records. Buffers them in a FIFO.

---
 rtl/tag_packer_pkg.sv | 37 +++
 rtl/tag_packer_if.sv | 39 +++
 rtl/tag_packer_fifo.sv | 71 +++++++
 rtl/tag_packer.sv | 134 +++++++++++++
 4 files changed

// File: rtl/tag_packer_pkg.sv
// Shared types and constants for the tag packer.
//   REC_BYTES   bytes per serialised record (header + 5 timestamp bytes)
//   TIME_W      timestamp width
//   CHAN_W      channel width
//   HDR_OVF_BIT header bit that marks "events were lost before this record"
//   tag_rec_t   one FIFO entry: overflow flag, channel, timestamp (45 bits)
//   send_state_t send FSM state, also exported for debug
package tag_pkg;

  localparam int REC_BYTES   = 6;
  localparam int TIME_W      = 40;
  localparam int CHAN_W      = 4;
  localparam int HDR_OVF_BIT = 7;
  localparam int REC_W       = REC_BYTES * 8;
  localparam int FIFO_W      = 1 + CHAN_W + TIME_W;

  typedef struct packed {
    logic              ovf;
    logic [CHAN_W-1:0] chan;
    logic [TIME_W-1:0] tstamp;
  } tag_rec_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } send_state_t;

  // Header byte is {ovf, 3'b000, chan}; timestamp follows MSB first.
  function automatic logic [REC_W-1:0] pack_record(input tag_rec_t r);
    logic [7:0] hdr;
    hdr              = '0;
    hdr[HDR_OVF_BIT] = r.ovf;
    hdr[CHAN_W-1:0]  = r.chan;
    return {hdr, r.tstamp};
  endfunction

endpackage

// File: rtl/tag_packer_if.sv
// Bus bundle of the tag packer: tagger-side ingress, lost-event status and
// the output-mux byte handshake.
//   slave  : view of the packer (inputs *_i, outputs *_o)
//   master : view of the environment driving the packer
//
// Output-mux handshake: omux_req_o acts as "valid" and omux_sel_i as "ready".
// While omux_req_o=1 the byte on omux_data_o is held stable; a byte is
// consumed on every cycle where omux_req_o and omux_sel_i are both 1, and the
// next byte appears in the following cycle. omux_req_o stays high for all six
// bytes of a record and drops for at least one cycle between records.
// omux_sel_i is ignored while omux_req_o=0.
interface tag_packer_if
  import tag_pkg::*;
#(
  parameter int LOST_W = 16
) ();

  logic              enable_i;
  logic              tag_valid_i;
  logic [CHAN_W-1:0] tag_chan_i;
  logic [TIME_W-1:0] tag_time_i;
  logic              lost_clr_i;
  logic [LOST_W-1:0] lost_count_o;
  logic              fifo_full_o;
  logic              omux_req_o;
  logic              omux_sel_i;
  logic [7:0]        omux_data_o;

  modport slave (
    input  enable_i, tag_valid_i, tag_chan_i, tag_time_i, lost_clr_i, omux_sel_i,
    output lost_count_o, fifo_full_o, omux_req_o, omux_data_o
  );

  modport master (
    output enable_i, tag_valid_i, tag_chan_i, tag_time_i, lost_clr_i, omux_sel_i,
    input  lost_count_o, fifo_full_o, omux_req_o, omux_data_o
  );

endinterface

// File: rtl/tag_packer_fifo.sv
// Synchronous FIFO with registered full/empty flags and show-ahead read:
// rd_data_o always presents the oldest entry, rd_en_i retires it.
//   clk_i, nreset_i   clock, async active-low reset
//   wr_en_i/wr_data_i write port (ignored when full)
//   rd_en_i/rd_data_o read port (ignored when empty)
//   full_o, empty_o   level after the last clock edge
module tag_fifo #(
  parameter int WIDTH = 45,
  parameter int DEPTH = 16
) (
  input  logic             clk_i,
  input  logic             nreset_i,
  input  logic             wr_en_i,
  input  logic [WIDTH-1:0] wr_data_i,
  input  logic             rd_en_i,
  output logic [WIDTH-1:0] rd_data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [AW:0]   CNT_ONE  = (AW + 1)'(1);
  localparam logic [AW:0]   FULL_LVL = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      count_q, count_d;
  logic             full_q, empty_q;
  logic             wr_ok, rd_ok;

  // Full is registered, so a write against a full FIFO is dropped even when
  // a pop happens in the same cycle.
  assign wr_ok = wr_en_i & ~full_q;
  assign rd_ok = rd_en_i & ~empty_q;

  always_comb begin
    count_d = count_q;
    if (wr_ok && !rd_ok) begin
      count_d = count_q + CNT_ONE;
    end else if (!wr_ok && rd_ok) begin
      count_d = count_q - CNT_ONE;
    end
  end

  always_ff @(posedge clk_i or negedge nreset_i) begin
    if (!nreset_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      if (wr_ok) wr_ptr_q <= wr_ptr_q + PTR_ONE;
      if (rd_ok) rd_ptr_q <= rd_ptr_q + PTR_ONE;
      count_q <= count_d;
      full_q  <= (count_d == FULL_LVL);
      empty_q <= (count_d == '0);
    end
  end

  // Storage needs no reset; the flags guard against reading stale entries.
  always_ff @(posedge clk_i) begin
    if (wr_ok) mem_q[wr_ptr_q] <= wr_data_i;
  end

  assign rd_data_o = mem_q[rd_ptr_q];
  assign full_o    = full_q;
  assign empty_o   = empty_q;

endmodule

// File: rtl/tag_packer.sv
// Packs tagger events into 6-byte records, buffers them and serialises them
// byte by byte to an output-mux slot.
//   clk_i        system clock
//   nreset_i     async active-low reset
//   bus_io       tag ingress, lost-event status and output-mux handshake
//   dbg_state_o  current send FSM state
module tag_packer
  import tag_pkg::*;
#(
  parameter int FIFO_DEPTH = 16,
  parameter int LOST_W     = 16
) (
  input  logic         clk_i,
  input  logic         nreset_i,
  tag_packer_if.slave  bus_io,
  output send_state_t  dbg_state_o
);

  localparam logic [LOST_W-1:0] LOST_ONE  = LOST_W'(1);
  localparam logic [LOST_W-1:0] LOST_MAX  = '1;
  localparam logic [2:0]        CNT_ONE   = 3'd1;
  localparam logic [2:0]        LAST_BYTE = 3'(REC_BYTES - 1);

  // ---------------- ingress and lost-event accounting ----------------
  logic              fifo_full, fifo_empty, pop;
  logic              accept, drop;
  logic              ovf_pend_q, ovf_pend_d;
  logic [LOST_W-1:0] lost_q, lost_d;
  tag_rec_t          wr_rec, rd_rec;
  logic [FIFO_W-1:0] fifo_rd_data;

  assign accept = bus_io.enable_i & bus_io.tag_valid_i & ~fifo_full;
  assign drop   = bus_io.enable_i & bus_io.tag_valid_i &  fifo_full;

  assign wr_rec.ovf    = ovf_pend_q;
  assign wr_rec.chan   = bus_io.tag_chan_i;
  assign wr_rec.tstamp = bus_io.tag_time_i;

  always_comb begin
    ovf_pend_d = ovf_pend_q;
    if (drop) begin
      ovf_pend_d = 1'b1;
    end else if (accept) begin
      ovf_pend_d = 1'b0;
    end
  end

  // A clear that coincides with a drop still counts that drop.
  always_comb begin
    lost_d = lost_q;
    if (bus_io.lost_clr_i) begin
      lost_d = drop ? LOST_ONE : '0;
    end else if (drop && (lost_q != LOST_MAX)) begin
      lost_d = lost_q + LOST_ONE;
    end
  end

  always_ff @(posedge clk_i or negedge nreset_i) begin
    if (!nreset_i) begin
      ovf_pend_q <= 1'b0;
      lost_q     <= '0;
    end else begin
      ovf_pend_q <= ovf_pend_d;
      lost_q     <= lost_d;
    end
  end

  tag_fifo #(
    .WIDTH (FIFO_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i     (clk_i),
    .nreset_i  (nreset_i),
    .wr_en_i   (accept),
    .wr_data_i (wr_rec),
    .rd_en_i   (pop),
    .rd_data_o (fifo_rd_data),
    .full_o    (fifo_full),
    .empty_o   (fifo_empty)
  );

  assign rd_rec = tag_rec_t'(fifo_rd_data);

  // ---------------- send FSM and shift register ----------------
  send_state_t      state_q, state_d;
  logic [REC_W-1:0] shreg_q, shreg_d;
  logic [2:0]       byte_cnt_q, byte_cnt_d;

  // The IDLE cycle spent loading the next record is what guarantees the
  // one-cycle request gap between records.
  always_comb begin
    state_d    = state_q;
    shreg_d    = shreg_q;
    byte_cnt_d = byte_cnt_q;
    pop        = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          pop        = 1'b1;
          shreg_d    = pack_record(rd_rec);
          byte_cnt_d = '0;
          state_d    = ST_SEND;
        end
      end
      ST_SEND: begin
        if (bus_io.omux_sel_i) begin
          shreg_d    = {shreg_q[REC_W-9:0], 8'h00};
          byte_cnt_d = byte_cnt_q + CNT_ONE;
          if (byte_cnt_q == LAST_BYTE) state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge nreset_i) begin
    if (!nreset_i) begin
      state_q    <= ST_IDLE;
      shreg_q    <= '0;
      byte_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      shreg_q    <= shreg_d;
      byte_cnt_q <= byte_cnt_d;
    end
  end

  assign bus_io.omux_req_o   = (state_q == ST_SEND);
  assign bus_io.omux_data_o  = (state_q == ST_SEND) ? shreg_q[REC_W-1 -: 8] : 8'h00;
  assign bus_io.lost_count_o = lost_q;
  assign bus_io.fifo_full_o  = fifo_full;
  assign dbg_state_o         = state_q;

endmodule
